adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_stage.sv | 60 ++++++
 rtl/adder_pipe.sv | 72 +++++++
 tb/tb_adder_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Holds the default geometry and the per-stage chunk width calculation.
package adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Bits summed by each stage; WIDTH is expected to be a multiple of STAGES.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One slice of the pipelined adder: adds chunk IDX of both operands plus the
// incoming carry, forwards the operands and the partial sum to the next slice.
module adder_stage #(
  parameter int WIDTH = 16,
  parameter int CW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  input  logic             next_advance,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             advance
);

  localparam int LO = IDX * CW;

  logic [CW:0]      chunk;
  logic [WIDTH-1:0] next_sum;

  assign chunk = {1'b0, prev_a[LO +: CW]} + {1'b0, prev_b[LO +: CW]}
               + {{CW{1'b0}}, prev_carry};

  // NOTE: every bit of next_sum is defaulted before the chunk overwrite, so no latch is inferred.
  always_comb begin
    next_sum            = prev_sum;
    next_sum[LO +: CW]  = chunk[CW-1:0];
  end

  // A slot may load when it is empty or its contents move on this cycle.
  assign advance = !valid || next_advance;

  // NOTE: non-blocking assignments keep all slices updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, because the last slice drives the
      // block's outputs directly and they must read zero during reset.
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      a     <= prev_a;
      b     <= prev_b;
      sum   <= next_sum;
      carry <= chunk[CW];
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple adder with valid/ready handshakes and bubble collapsing.
// Optional macro ADDER_PIPE_SAT_EN saturates out_data to all-ones on overflow.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             cy,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  // Index k is the input side of slice k; index STAGES is the block output.
  logic [STAGES:0]  valid_s;
  logic [STAGES:0]  carry_s;
  logic [STAGES:0]  adv_s;
  logic [WIDTH-1:0] a_s   [STAGES+1];
  logic [WIDTH-1:0] b_s   [STAGES+1];
  logic [WIDTH-1:0] sum_s [STAGES+1];

  assign valid_s[0]     = in_valid;
  assign carry_s[0]     = cin;
  assign a_s[0]         = in_data1;
  assign b_s[0]         = in_data2;
  assign sum_s[0]       = '0;
  assign adv_s[STAGES]  = out_ready;
  assign in_ready       = adv_s[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .prev_valid   (valid_s[k]),
      .prev_a       (a_s[k]),
      .prev_b       (b_s[k]),
      .prev_sum     (sum_s[k]),
      .prev_carry   (carry_s[k]),
      .next_advance (adv_s[k+1]),
      .valid        (valid_s[k+1]),
      .a            (a_s[k+1]),
      .b            (b_s[k+1]),
      .sum          (sum_s[k+1]),
      .carry        (carry_s[k+1]),
      .advance      (adv_s[k])
    );
  end

  assign out_valid = valid_s[STAGES];
  assign cy        = carry_s[STAGES];

`ifdef ADDER_PIPE_SAT_EN
  assign out_data = cy ? '1 : sum_s[STAGES];
`else
  assign out_data = sum_s[STAGES];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: vector table, directed handshake
// sequences and a randomized run against an arithmetic reference queue.
module tb_adder_pipe;

  localparam int W = 16;
  localparam int S = 4;
`ifdef ADDER_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data1, in_data2, out_data;
  logic          cin, in_valid, in_ready, cy, out_valid, out_ready;

  logic [7:0]    d1_a, d1_b, d1_out;
  logic          d1_cin, d1_in_valid, d1_in_ready, d1_cy, d1_out_valid, d1_out_ready;

  adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .cy        (cy),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data1  (d1_a),
    .in_data2  (d1_b),
    .cin       (d1_cin),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .out_data  (d1_out),
    .cy        (d1_cy),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] wrap;
    logic        cy;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        cy;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, wrap/saturate applied afterwards.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    int unsigned s;
    res_t r;
    s      = 32'(a) + 32'(b) + 32'(c);
    r.cy   = (s > 32'h0000_FFFF);
    r.data = 16'(s % 65536);
    if (SAT && r.cy) r.data = 16'hFFFF;
    return r;
  endfunction

  // Drives one cycle, checks any presented result against the queue head,
  // and records accepted operands. fired = a result transfers this cycle.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic ordy, output logic fired);
    @(negedge clk);
    in_valid  = v;
    in_data1  = a;
    in_data2  = b;
    cin       = c;
    out_ready = ordy;
    #1;
    fired = out_valid && out_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        check("cy", {31'd0, cy}, {31'd0, exp_q[0].cy});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(a, b, c));
  endtask

  vec_t tbl[7];
  logic f;
  int   lat, cnt, first, last, acc;
  logic [15:0] exp_d;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    tbl[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    in_valid = 0; in_data1 = 0; in_data2 = 0; cin = 0; out_ready = 0;
    d1_a = 0; d1_b = 0; d1_cin = 0; d1_in_valid = 0; d1_out_ready = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {16'd0, out_data}, 32'd0);
    check("reset_cy", {31'd0, cy}, 32'd0);
    check("reset_d1_out_valid", {31'd0, d1_out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Vector table: single transfers, latency and result per vector.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1; in_data1 = tbl[i].a; in_data2 = tbl[i].b; cin = tbl[i].c; out_ready = 1;
      #1;
      check("tbl_in_ready", {31'd0, in_ready}, 32'd1);
      lat = 0;
      do begin
        @(negedge clk);
        in_valid = 0;
        #1;
        lat++;
      end while (!out_valid && lat < 20);
      exp_d = (SAT && tbl[i].cy) ? 16'hFFFF : tbl[i].wrap;
      check("tbl_latency", lat, S);
      check("tbl_out_data", {16'd0, out_data}, {16'd0, exp_d});
      check("tbl_cy", {31'd0, cy}, {31'd0, tbl[i].cy});
    end
    @(negedge clk);
    #1;
    check("tbl_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back i+i: eight results on eight consecutive cycles.
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      step(c < 8, 16'(c), 16'(c), 1'b0, 1'b1, f);
      if (c < 8) check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (f) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    check("b2b_count", cnt, 8);
    check("b2b_first_cycle", first, S);
    check("b2b_consecutive", last - first, 7);

    // Backpressure: fill with out_ready low, then drain while accepting.
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 16'h1000 + 16'(c), 16'h0F00, 1'b1, 1'b0, f);
      if (in_ready) acc++;
    end
    check("fill_accepts", acc, S);
    check("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, f);
    step(1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b1, f);
    check("full_accept_on_drain", {31'd0, in_ready}, 32'd1);
    repeat (10) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, f);
    check("drain_queue_empty", exp_q.size(), 0);

    // Reset with three results in flight, head already presented.
    for (int c = 0; c < 3; c++) step(1'b1, 16'hA000 + 16'(c), 16'h7000, 1'b0, 1'b0, f);
    repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, f);
    check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out_data", {16'd0, out_data}, 32'd0);
    check("midreset_cy", {31'd0, cy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_midreset", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, f);
      if (f) cnt++;
    end
    check("no_stale_results", cnt, 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, f);
    end
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, f);
    check("random_queue_empty", exp_q.size(), 0);
    in_valid = 0;

    // Single-stage, 8-bit instance: registered adder with latency 1.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d1_in_valid = 1;
      d1_a   = (i == 0) ? 8'hF0 : 8'h05;
      d1_b   = (i == 0) ? 8'h20 : 8'h03;
      d1_cin = (i == 0) ? 1'b0  : 1'b1;
      #1;
      check("d1_in_ready", {31'd0, d1_in_ready}, 32'd1);
      @(negedge clk);
      d1_in_valid = 0;
      #1;
      check("d1_out_valid", {31'd0, d1_out_valid}, 32'd1);
      if (i == 0) begin
        check("d1_out_data", {24'd0, d1_out}, SAT ? 32'hFF : 32'h10);
        check("d1_cy", {31'd0, d1_cy}, 32'd1);
      end else begin
        check("d1_out_data", {24'd0, d1_out}, 32'h09);
        check("d1_cy", {31'd0, d1_cy}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
